// File: rtl/eth_pkg.sv
// rtl/eth_pkg.sv - shared write-FSM state type and pointer width helper for the frame fifo
// Contents: wr_state_t (write-side FSM states), ptr_width() (address bits for a given depth).
package eth_pkg;

   typedef enum logic {
      WR_WRITE = 1'b0,
      WR_DROP  = 1'b1
   } wr_state_t;

   localparam int FRAMES_W = 16;

   function automatic int ptr_width(input int depth);
      return $clog2(depth);
   endfunction

endpackage

// File: rtl/eth_fifo_ram.sv
// rtl/eth_fifo_ram.sv - simple dual-port RAM with registered read, contents never reset
// Ports: clk; wr_en/wr_addr/wr_data write port; rd_en/rd_addr read request; rd_data registered,
//        holds its value while rd_en is low.
module eth_fifo_ram
   import eth_pkg::*;
#(
   parameter int WIDTH = 10,
   parameter int DEPTH = 16,
   localparam int AW   = ptr_width(DEPTH)
) (
   input  logic             clk,
   input  logic             wr_en,
   input  logic [AW-1:0]    wr_addr,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             rd_en,
   input  logic [AW-1:0]    rd_addr,
   output logic [WIDTH-1:0] rd_data
);

   logic [WIDTH-1:0] mem [0:DEPTH-1];

   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_addr] <= wr_data;
      if (rd_en) rd_data <= mem[rd_addr];
   end

endmodule

// File: rtl/eth_axis_frame_fifo.sv
// rtl/eth_axis_frame_fifo.sv - store-and-forward AXI-Stream frame fifo with bad/oversize frame drop
// Ports: logic_clk, logic_rst_n (async active-low); s_axis_* frame input (tuser=1 marks a bad frame);
//        m_axis_* frame output (tuser always 0); status_overflow/bad_frame/good_frame one-cycle pulses;
//        status_depth committed words held; status_frames committed frames not yet fully read.
module eth_axis_frame_fifo
   import eth_pkg::*;
#(
   parameter int DATA_WIDTH     = 8,
   parameter int KEEP_WIDTH     = DATA_WIDTH / 8,
   parameter int DEPTH          = 4096,
   parameter bit DROP_BAD_FRAME = 1'b1,
   parameter bit DROP_WHEN_FULL = 1'b0,
   localparam int AW            = ptr_width(DEPTH)
) (
   input  logic                  logic_clk,
   input  logic                  logic_rst_n,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic                  s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic                  m_axis_tuser,
   output logic                  status_overflow,
   output logic                  status_bad_frame,
   output logic                  status_good_frame,
   output logic [AW:0]           status_depth,
   output logic [FRAMES_W-1:0]   status_frames
);

   localparam int          RW      = DATA_WIDTH + KEEP_WIDTH + 1;
   localparam logic [AW:0] DEPTH_P = DEPTH[AW:0];

   wr_state_t     state, state_nxt;
   logic [AW:0]   wr_ptr, wr_commit, rd_ptr;
   logic [AW:0]   wr_ptr_nxt, wr_commit_nxt;
   logic          good_nxt, bad_nxt, ovf_nxt, mem_we;
   logic          ready_en, xfer_in, full, oversize;
   logic          s1_valid, adv2, rd_en, rd_empty, fr_dec;
   logic [RW-1:0] ram_q;

   assign full     = (wr_ptr - rd_ptr) == DEPTH_P;
   // The frame in progress fills the whole RAM by itself: it can never commit.
   assign oversize = (wr_ptr - wr_commit) == DEPTH_P;
   assign xfer_in  = s_axis_tvalid && s_axis_tready;

   // ready_en keeps tready low while in reset and through the release cycle.
   always_comb begin
      s_axis_tready = 1'b0;
      if (ready_en) begin
         if (state == WR_DROP || DROP_WHEN_FULL) s_axis_tready = 1'b1;
         else                                     s_axis_tready = !full;
      end
   end

   always_comb begin
      state_nxt     = state;
      wr_ptr_nxt    = wr_ptr;
      wr_commit_nxt = wr_commit;
      mem_we        = 1'b0;
      good_nxt      = 1'b0;
      bad_nxt       = 1'b0;
      ovf_nxt       = 1'b0;
      if (state == WR_WRITE) begin
         if (oversize || (xfer_in && full)) begin
            wr_ptr_nxt = wr_commit;
            // A frame whose tlast is the word that hits the wall ends here.
            if (xfer_in && s_axis_tlast) ovf_nxt   = 1'b1;
            else                         state_nxt = WR_DROP;
         end else if (xfer_in) begin
            mem_we     = 1'b1;
            wr_ptr_nxt = wr_ptr + 1'b1;
            if (s_axis_tlast) begin
               if (s_axis_tuser && DROP_BAD_FRAME) begin
                  wr_ptr_nxt = wr_commit;
                  bad_nxt    = 1'b1;
               end else begin
                  wr_commit_nxt = wr_ptr + 1'b1;
                  good_nxt      = 1'b1;
               end
            end
         end
      end else begin
         if (xfer_in && s_axis_tlast) begin
            state_nxt = WR_WRITE;
            ovf_nxt   = 1'b1;
         end
      end
   end

   // Read pipeline: stage 1 is the RAM output register, stage 2 the m_axis register.
   assign rd_empty = rd_ptr == wr_commit;
   assign adv2     = s1_valid && (!m_axis_tvalid || m_axis_tready);
   assign rd_en    = !rd_empty && (!s1_valid || adv2);
   assign fr_dec   = m_axis_tvalid && m_axis_tready && m_axis_tlast;

   eth_fifo_ram #(.WIDTH(RW), .DEPTH(DEPTH)) u_ram (
      .clk     (logic_clk),
      .wr_en   (mem_we),
      .wr_addr (wr_ptr[AW-1:0]),
      .wr_data ({s_axis_tlast, s_axis_tkeep, s_axis_tdata}),
      .rd_en   (rd_en),
      .rd_addr (rd_ptr[AW-1:0]),
      .rd_data (ram_q)
   );

   always_ff @(posedge logic_clk or negedge logic_rst_n) begin
      if (!logic_rst_n) begin
         state             <= WR_WRITE;
         wr_ptr            <= '0;
         wr_commit         <= '0;
         rd_ptr            <= '0;
         ready_en          <= 1'b0;
         s1_valid          <= 1'b0;
         m_axis_tvalid     <= 1'b0;
         status_overflow   <= 1'b0;
         status_bad_frame  <= 1'b0;
         status_good_frame <= 1'b0;
         status_depth      <= '0;
         status_frames     <= '0;
      end else begin
         state             <= state_nxt;
         wr_ptr            <= wr_ptr_nxt;
         wr_commit         <= wr_commit_nxt;
         ready_en          <= 1'b1;
         status_overflow   <= ovf_nxt;
         status_bad_frame  <= bad_nxt;
         status_good_frame <= good_nxt;
         status_depth      <= wr_commit - rd_ptr;
         if (rd_en) rd_ptr <= rd_ptr + 1'b1;
         if (rd_en)     s1_valid <= 1'b1;
         else if (adv2) s1_valid <= 1'b0;
         if (adv2)               m_axis_tvalid <= 1'b1;
         else if (m_axis_tready) m_axis_tvalid <= 1'b0;
         if (good_nxt && !fr_dec && status_frames != '1)
            status_frames <= status_frames + 1'b1;
         else if (!good_nxt && fr_dec && status_frames != '0)
            status_frames <= status_frames - 1'b1;
      end
   end

   always_ff @(posedge logic_clk) begin
      if (adv2) {m_axis_tlast, m_axis_tkeep, m_axis_tdata} <= ram_q;
   end

   assign m_axis_tuser = 1'b0;

endmodule
